muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer for the MIPS execute stage, holding the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO from the decode/ALU-control path and runs one shift-add or restoring-subtract step per cycle. While an operation is in flight it raises a structural-hazard stall toward the pipeline control, so the single-cycle ALU remains free for other instructions.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide sequencer owning the HI/LO registers.
//   i_clock       rising-edge clock
//   i_reset       synchronous active-low reset
//   i_valid       EX instruction is a mul/div or HI/LO move
//   i_funct       R-type funct (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO)
//   i_rs, i_rt    operands; i_rs is also the MTHI/MTLO source
//   i_flush       squash the in-flight operation
//   o_result      HI or LO for MFHI/MFLO, combinational
//   o_stall       structural-hazard stall toward pipeline control
//   o_busy        operation in flight
//   o_done        one-cycle pulse after HI/LO are written by a mul/div
//   o_div_by_zero one-cycle pulse with o_done when the divisor was zero
module muldiv_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = $clog2(NB_DATA)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_rs,
    input  logic [NB_DATA-1:0]  i_rt,
    input  logic                i_flush,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_stall,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_div_by_zero
);
    localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);
    localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t                 r_state, w_next;
    logic [NB_DATA-1:0]     r_hi, r_lo, r_opd, r_rs;
    logic [2*NB_DATA-1:0]   r_acc;
    logic [NB_COUNT-1:0]    r_count;
    logic                   r_div, r_neg_q, r_neg_r, r_dz, r_done, r_dz_pulse;

    logic                   w_idle, w_muldiv, w_move, w_signed, w_is_div, w_accept;
    logic                   w_rs_neg, w_rt_neg, w_ge;
    logic [NB_DATA-1:0]     w_rs_abs, w_rt_abs, w_sub, w_q, w_r, w_fix_hi, w_fix_lo;
    logic [NB_DATA:0]       w_add, w_shl;
    logic [2*NB_DATA-1:0]   w_step, w_prod;

    assign w_idle   = r_state == S_IDLE;
    assign w_muldiv = i_funct == F_MULT || i_funct == F_MULTU || i_funct == F_DIV || i_funct == F_DIVU;
    assign w_move   = i_funct == F_MFHI || i_funct == F_MTHI || i_funct == F_MFLO || i_funct == F_MTLO;
    assign w_signed = i_funct == F_MULT || i_funct == F_DIV;
    assign w_is_div = i_funct == F_DIV || i_funct == F_DIVU;
    assign w_accept = w_idle && i_valid && w_muldiv && !i_flush;
    assign w_rs_neg = w_signed && i_rs[NB_DATA-1];
    assign w_rt_neg = w_signed && i_rt[NB_DATA-1];
    assign w_rs_abs = w_rs_neg ? -i_rs : i_rs;
    assign w_rt_abs = w_rt_neg ? -i_rt : i_rt;

    // Multiply: acc = {partial product, remaining multiplier bits}, add then shift right.
    // Divide: acc = {partial remainder, dividend/quotient bits}, shift left then try subtract.
    assign w_add  = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + {1'b0, r_acc[0] ? r_opd : '0};
    assign w_shl  = r_acc[2*NB_DATA-1:NB_DATA-1];
    assign w_ge   = w_shl >= {1'b0, r_opd};
    // When the subtract succeeds the difference always fits in NB_DATA bits.
    assign w_sub  = w_shl[NB_DATA-1:0] - r_opd;
    assign w_step = !r_div ? {w_add, r_acc[NB_DATA-1:1]} :
                    w_ge   ? {w_sub, r_acc[NB_DATA-2:0], 1'b1} :
                             {w_shl[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0};

    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_q      = r_neg_q ? -r_acc[NB_DATA-1:0] : r_acc[NB_DATA-1:0];
    assign w_r      = r_neg_r ? -r_acc[2*NB_DATA-1:NB_DATA] : r_acc[2*NB_DATA-1:NB_DATA];
    assign w_fix_hi = r_dz ? r_rs : r_div ? w_r : w_prod[2*NB_DATA-1:NB_DATA];
    assign w_fix_lo = r_dz ? '1   : r_div ? w_q : w_prod[NB_DATA-1:0];

    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = w_idle              ? (w_accept ? S_CALC : S_IDLE) :
                 i_flush             ? S_IDLE :
                 r_state == S_CALC   ? (r_count == '0 ? S_FIX : S_CALC) :
                                       S_IDLE;
    end

    always_comb begin
        o_busy        = !w_idle;
        o_stall       = i_valid && (w_muldiv || (w_move && !w_idle));
        o_result      = (i_valid && w_idle && i_funct == F_MFHI) ? r_hi :
                        (i_valid && w_idle && i_funct == F_MFLO) ? r_lo : '0;
        o_done        = r_done;
        o_div_by_zero = r_dz_pulse;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_rs       <= '0;
            r_count    <= '0;
            r_div      <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_dz_pulse <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_dz_pulse <= 1'b0;
            if (w_accept) begin
                r_acc   <= {{NB_DATA{1'b0}}, w_is_div ? w_rs_abs : w_rt_abs};
                r_opd   <= w_is_div ? w_rt_abs : w_rs_abs;
                r_rs    <= i_rs;
                r_div   <= w_is_div;
                r_neg_q <= w_rs_neg ^ w_rt_neg;
                r_neg_r <= w_rs_neg;
                r_dz    <= w_is_div && i_rt == '0;
                r_count <= NB_COUNT'(NB_DATA - 1);
            end else if (r_state == S_CALC && !i_flush) begin
                r_acc   <= w_step;
                r_count <= r_count - NB_COUNT'(1);
            end else if (r_state == S_FIX && !i_flush) begin
                r_hi       <= w_fix_hi;
                r_lo       <= w_fix_lo;
                r_done     <= 1'b1;
                r_dz_pulse <= r_dz;
            end else if (w_idle && i_valid && !i_flush) begin
                if (i_funct == F_MTHI) r_hi <= i_rs;
                if (i_funct == F_MTLO) r_lo <= i_rs;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven check of muldiv_unit.
module tb_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [5:0]  i_funct = '0;
    logic [31:0] i_rs = '0;
    logic [31:0] i_rt = '0;
    logic        i_flush = 1'b0;
    logic [31:0] o_result;
    logic        o_stall, o_busy, o_done, o_div_by_zero;

    int checks = 0;
    int errors = 0;
    vec_t vecs[11];

    muldiv_unit dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_funct(i_funct),
        .i_rs(i_rs), .i_rt(i_rt), .i_flush(i_flush), .o_result(o_result),
        .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        i_valid = 1'b1;
        i_funct = F_MFHI;
        #1 chk({tag, " MFHI"}, o_result, hi);
        i_funct = F_MFLO;
        #1 chk({tag, " MFLO"}, o_result, lo);
        i_valid = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int busy_n = 0;
        int g = 0;
        string tag = $sformatf("vec%0d", idx);
        i_valid = 1'b1;
        i_funct = v.f;
        i_rs = v.rs;
        i_rt = v.rt;
        #1 chk({tag, " accept stall"}, o_stall, 1);
        @(negedge i_clock);
        i_valid = 1'b0;
        #1;
        while (!o_done && g < 100) begin
            busy_n += o_busy;
            g++;
            @(negedge i_clock);
            #1;
        end
        chk({tag, " done"}, o_done, 1);
        chk({tag, " busy cycles"}, busy_n, 33);
        chk({tag, " div_by_zero"}, o_div_by_zero, v.dz);
        chk({tag, " busy at done"}, o_busy, 0);
        read_hilo(tag, v.hi, v.lo);
        @(negedge i_clock);
        #1 chk({tag, " done pulse width"}, o_done, 0);
    endtask

    initial begin
        int n, g;
        vecs[0]  = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{F_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[6]  = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[7]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{F_DIVU,  32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

        repeat (2) @(negedge i_clock);
        #1;
        chk("reset busy", o_busy, 0);
        chk("reset done", o_done, 0);
        chk("reset dz", o_div_by_zero, 0);
        i_reset = 1'b1;
        read_hilo("reset", 32'h0, 32'h0);
        @(negedge i_clock);

        for (int i = 0; i < 11; i++) run_op(vecs[i], i);

        // MULTU followed by a dependent MFLO held valid: stalls until the o_done cycle.
        i_valid = 1'b1;
        i_funct = F_MULTU;
        i_rs = 32'hFFFFFFFF;
        i_rt = 32'hFFFFFFFF;
        @(negedge i_clock);
        i_funct = F_MFLO;
        n = 0;
        g = 0;
        #1;
        while (o_stall && g < 100) begin
            n++;
            g++;
            @(negedge i_clock);
            #1;
        end
        chk("mflo stall cycles", n, 33);
        chk("mflo done", o_done, 1);
        chk("mflo result", o_result, 32'h00000001);
        // Back-to-back: a new DIVU is accepted in the o_done cycle.
        i_funct = F_DIVU;
        i_rs = 32'd100;
        i_rt = 32'd7;
        #1 chk("b2b accept stall", o_stall, 1);
        @(negedge i_clock);
        i_valid = 1'b0;
        #1 chk("b2b busy", o_busy, 1);
        g = 0;
        while (!o_done && g < 100) begin
            g++;
            @(negedge i_clock);
            #1;
        end
        chk("b2b done", o_done, 1);
        read_hilo("b2b", 32'd2, 32'd14);
        @(negedge i_clock);

        // MTHI, then a DIV squashed mid-CALC leaves HI/LO untouched.
        i_valid = 1'b1;
        i_funct = F_MTHI;
        i_rs = 32'hA5A5A5A5;
        #1 chk("mthi stall", o_stall, 0);
        @(negedge i_clock);
        read_hilo("mthi", 32'hA5A5A5A5, 32'd14);
        i_valid = 1'b1;
        i_funct = F_DIV;
        i_rs = 32'd50;
        i_rt = 32'd3;
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (10) @(negedge i_clock);
        #1 chk("flush pre busy", o_busy, 1);
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        #1 chk("flush busy", o_busy, 0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            n += o_done;
            @(negedge i_clock);
        end
        chk("flush no done", n, 0);
        read_hilo("flush", 32'hA5A5A5A5, 32'd14);
        @(negedge i_clock);
        // MTLO squashed in IDLE is not written.
        i_valid = 1'b1;
        i_funct = F_MTLO;
        i_rs = 32'hDEADBEEF;
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        read_hilo("mtlo flush", 32'hA5A5A5A5, 32'd14);
        @(negedge i_clock);

        // Reset asserted mid-CALC.
        i_valid = 1'b1;
        i_funct = F_MULT;
        i_rs = 32'd3;
        i_rt = 32'd5;
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (5) @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        #1 chk("midreset busy", o_busy, 0);
        i_valid = 1'b1;
        i_funct = F_MFHI;
        #1 chk("midreset stall", o_stall, 0);
        i_valid = 1'b0;
        read_hilo("midreset", 32'h0, 32'h0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            n += o_done;
            @(negedge i_clock);
        end
        chk("midreset no done", n, 0);

        // Unrecognised funct: no stall, zero result, nothing started.
        i_valid = 1'b1;
        i_funct = 6'b100000;
        i_rs = 32'h11111111;
        #1 chk("unrec stall", o_stall, 0);
        chk("unrec result", o_result, 32'h0);
        @(negedge i_clock);
        i_valid = 1'b0;
        #1 chk("unrec busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
